sprite_renderer_anim: RTL and testbench

- Parametrised, pipelined sprite renderer for the VGA path; successor to the fixed 4x4 ROM-sprite block.
- Holds FRAMES animation frames of SPRITE_W x SPRITE_H 8-bit colour codes in a write-loadable RAM, supports integer scaling, and auto-advances frames on vertical-blank ticks.
- Outputs registered RGB plus a visible flag for the pixel mixer; code TRANSP_CODE is transparent.

---
 rtl/sprite_renderer_anim.sv | 149 ++++++++++++++
 tb/tb_sprite_renderer_anim.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_renderer_anim.sv
// sprite_renderer_anim: 2-stage sprite renderer, loadable texel RAM,
// 2^scale zoom, vblank animation. Define MIRROR_EN to add flip_h.
module sprite_renderer_anim #(
    parameter int SPRITE_W = 4,
    parameter int SPRITE_H = 4,
    parameter int FRAMES = 4,
    parameter int FRAME_PERIOD = 15,
    parameter logic [7:0] TRANSP_CODE = 8'h00,
    localparam int DEPTH = FRAMES * SPRITE_W * SPRITE_H,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic          FPGA_Clock,
    input  logic          rst_n,
    input  logic [9:0]    x_pos,
    input  logic [9:0]    y_pos,
    input  logic [9:0]    h_count,
    input  logic [9:0]    v_count,
    input  logic [1:0]    scale,
    input  logic          frame_tick,
    input  logic          anim_en,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
`ifdef MIRROR_EN
    input  logic          flip_h,
`endif
    output logic [FW-1:0] frame_idx,
    output logic [23:0]   RGB,
    output logic          visible
);
    localparam int CNTW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FRAME_PERIOD - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);

    typedef enum logic {HOLD, RUN} anim_state_t;

    anim_state_t     state;
    logic [CNTW-1:0] tick_cnt;

    logic [7:0]  mem [DEPTH];

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        in_area;
    logic [9:0]  dh;
    logic [9:0]  dv;
    logic [9:0]  col_s;
    logic [9:0]  col;
    logic [9:0]  row;
    logic [AW-1:0] rd_addr;

    logic          in_area_d;
    logic [AW-1:0] addr_d;
    logic [7:0]    rd_code;
    logic [2:0]    r3;
    logic [2:0]    g3;
    logic [1:0]    b2;

    // 11-bit edges so a sprite near column 1023 clips instead of wrapping
    assign x_end = {1'b0, x_pos} + (11'(SPRITE_W) << scale);
    assign y_end = {1'b0, y_pos} + (11'(SPRITE_H) << scale);
    assign in_area = (h_count >= x_pos) && ({1'b0, h_count} < x_end)
                  && (v_count >= y_pos) && ({1'b0, v_count} < y_end);

    assign dh = h_count - x_pos;
    assign dv = v_count - y_pos;
    assign col_s = dh >> scale;
    assign row = dv >> scale;

`ifdef MIRROR_EN
    assign col = flip_h ? (10'(SPRITE_W - 1) - col_s) : col_s;
`else
    assign col = col_s;
`endif

    assign rd_addr = AW'(int'(frame_idx) * SPRITE_W * SPRITE_H
                       + int'(row) * SPRITE_W + int'(col));

    assign rd_code = mem[addr_d];
    assign r3 = rd_code[7:5];
    assign g3 = rd_code[4:2];
    assign b2 = rd_code[1:0];

    // Texel RAM write port; reads in the same edge see the old contents
    always_ff @(posedge FPGA_Clock) begin
        if (rst_n && wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Stage 1: area flag and texel address
    always_ff @(posedge FPGA_Clock) begin
        if (!rst_n) begin
            in_area_d <= 1'b0;
            addr_d    <= '0;
        end else begin
            in_area_d <= in_area;
            addr_d    <= rd_addr;
        end
    end

    // Stage 2: RAM read, transparency and RGB332 expansion
    always_ff @(posedge FPGA_Clock) begin
        if (!rst_n) begin
            visible <= 1'b0;
            RGB     <= 24'h0;
        end else if (in_area_d && (rd_code != TRANSP_CODE)) begin
            visible <= 1'b1;
            RGB     <= {r3, r3, r3[2:1], g3, g3, g3[2:1], b2, b2, b2, b2};
        end else begin
            visible <= 1'b0;
            RGB     <= 24'h0;
        end
    end

    // Animation FSM: counts vblank ticks only while running
    always_ff @(posedge FPGA_Clock) begin
        if (!rst_n) begin
            state     <= HOLD;
            tick_cnt  <= '0;
            frame_idx <= '0;
        end else begin
            unique case (state)
                HOLD: begin
                    tick_cnt <= '0;
                    if (anim_en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!anim_en) begin
                        state    <= HOLD;
                        tick_cnt <= '0;
                    end else if (frame_tick) begin
                        if (tick_cnt == CNT_LAST) begin
                            tick_cnt  <= '0;
                            frame_idx <= (frame_idx == FRAME_LAST)
                                         ? '0 : frame_idx + 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_renderer_anim.sv
// tb_sprite_renderer_anim: directed pixel table, animation and collision
// sequences, then random traffic against a spec-level reference model.
module tb_sprite_renderer_anim;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [9:0]  x_pos, y_pos, h_count, v_count;
    logic [1:0]  scale;
    logic        frame_tick, anim_en, wr_en;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  frame_idx;
    logic [23:0] RGB;
    logic        visible;

    sprite_renderer_anim dut (
        .FPGA_Clock(clk),
        .rst_n(rst_n),
        .x_pos(x_pos),
        .y_pos(y_pos),
        .h_count(h_count),
        .v_count(v_count),
        .scale(scale),
        .frame_tick(frame_tick),
        .anim_en(anim_en),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .frame_idx(frame_idx),
        .RGB(RGB),
        .visible(visible)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0]  mm [64];
    int          mframe, mcnt;
    bit          mrun;
    bit          s1_in;
    int          s1_addr;
    bit          e_vis;
    logic [23:0] e_rgb;

    logic [7:0] f0 [16] = '{
        8'h03, 8'h92, 8'h49, 8'hFF,
        8'h24, 8'h6D, 8'hE0, 8'h00,
        8'h1F, 8'hE3, 8'h5A, 8'hB6,
        8'h01, 8'h80, 8'h7C, 8'hC0
    };

    typedef struct {
        int          x, y, s, h, v;
        bit          vis;
        logic [23:0] rgb;
        string       name;
    } pix_vec_t;

    pix_vec_t tbl [24];

    function automatic logic [23:0] dec(input logic [7:0] c);
        logic [2:0] r, g;
        logic [1:0] b;
        r = c[7:5];
        g = c[4:2];
        b = c[1:0];
        return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clock: advance the model, clock the DUT, compare
    task automatic tick_clk();
        logic [7:0] c;
        int hh, vv, xx, yy, sw, sh;
        if (!rst_n) begin
            e_vis = 0; e_rgb = 0; s1_in = 0; s1_addr = 0;
            mframe = 0; mcnt = 0; mrun = 0;
        end else begin
            c = s1_in ? mm[s1_addr] : 8'h00;
            e_vis = s1_in && (c != 8'h00);
            e_rgb = e_vis ? dec(c) : 24'h0;
            hh = int'(h_count); vv = int'(v_count);
            xx = int'(x_pos); yy = int'(y_pos);
            sw = 4 << scale; sh = 4 << scale;
            s1_in = (hh >= xx) && (hh < xx + sw) && (vv >= yy) && (vv < yy + sh);
            s1_addr = s1_in ? mframe * 16 + ((vv - yy) >> scale) * 4
                              + ((hh - xx) >> scale) : 0;
            if (wr_en) mm[wr_addr] = wr_data;
            if (mrun && anim_en && frame_tick) begin
                mcnt++;
                if (mcnt == 15) begin
                    mcnt = 0;
                    mframe = (mframe + 1) % 4;
                end
            end
            if (!anim_en) mcnt = 0;
            mrun = anim_en;
        end
        @(posedge clk);
        #1;
        check("model_vis", 32'(visible), 32'(e_vis));
        check("model_rgb", 32'(RGB), 32'(e_rgb));
        check("model_frame", 32'(frame_idx), 32'(mframe));
    endtask

    task automatic set_pix(input int x, input int y, input int s,
                           input int h, input int v);
        x_pos = 10'(x); y_pos = 10'(y); scale = 2'(s);
        h_count = 10'(h); v_count = 10'(v);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_clk();
    endtask

    task automatic frame_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1; tick_clk();
            frame_tick = 0; tick_clk();
        end
    endtask

    initial begin
        tbl[0]  = '{100, 50, 0, 102, 51, 1, 24'hFF0000, "hit_r1c2"};
        tbl[1]  = '{100, 50, 0, 104, 51, 0, 24'h0, "edge_x"};
        tbl[2]  = '{100, 50, 0, 99, 51, 0, 24'h0, "left_out"};
        tbl[3]  = '{100, 50, 0, 100, 50, 1, 24'h0000FF, "r0c0"};
        tbl[4]  = '{100, 50, 0, 103, 53, 1, 24'hDB0000, "r3c3"};
        tbl[5]  = '{100, 50, 0, 100, 54, 0, 24'h0, "edge_y"};
        tbl[6]  = '{100, 50, 0, 101, 51, 1, 24'h6D6D55, "r1c1"};
        tbl[7]  = '{100, 50, 0, 103, 51, 0, 24'h0, "transp_r1c3"};
        tbl[8]  = '{100, 50, 2, 100, 50, 1, 24'h0000FF, "s2_h100"};
        tbl[9]  = '{100, 50, 2, 103, 50, 1, 24'h0000FF, "s2_h103"};
        tbl[10] = '{100, 50, 2, 115, 50, 1, 24'hFFFFFF, "s2_h115"};
        tbl[11] = '{100, 50, 2, 116, 50, 0, 24'h0, "s2_h116"};
        tbl[12] = '{100, 50, 2, 115, 65, 1, 24'hDB0000, "s2_r3c3"};
        tbl[13] = '{100, 50, 2, 115, 66, 0, 24'h0, "s2_v66"};
        tbl[14] = '{1020, 50, 0, 1021, 50, 1, 24'h9292AA, "x1020_h1021"};
        tbl[15] = '{1020, 50, 0, 1023, 50, 1, 24'hFFFFFF, "x1020_h1023"};
        tbl[16] = '{1020, 50, 0, 0, 50, 0, 24'h0, "nowrap_h0"};
        tbl[17] = '{1020, 50, 0, 1, 50, 0, 24'h0, "nowrap_h1"};
        tbl[18] = '{1020, 50, 0, 2, 50, 0, 24'h0, "nowrap_h2"};
        tbl[19] = '{100, 50, 1, 102, 52, 1, 24'h6D6D55, "s1_r1c1"};
        tbl[20] = '{100, 50, 1, 107, 50, 1, 24'hFFFFFF, "s1_c3"};
        tbl[21] = '{100, 50, 1, 108, 50, 0, 24'h0, "s1_out"};
        tbl[22] = '{100, 50, 3, 131, 81, 1, 24'hDB0000, "s3_far"};
        tbl[23] = '{100, 1020, 0, 100, 1, 0, 24'h0, "nowrap_v"};

        rst_n = 0; frame_tick = 0; anim_en = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        set_pix(100, 50, 0, 0, 0);
        ticks(2);
        rst_n = 1;

        for (int i = 0; i < 64; i++) begin
            wr_en = 1;
            wr_addr = 6'(i);
            wr_data = (i < 16) ? f0[i] : 8'($urandom);
            tick_clk();
        end
        wr_en = 0;

        for (int i = 0; i < 24; i++) begin
            set_pix(tbl[i].x, tbl[i].y, tbl[i].s, tbl[i].h, tbl[i].v);
            ticks(3);
            check({tbl[i].name, "_vis"}, 32'(visible), 32'(tbl[i].vis));
            check({tbl[i].name, "_rgb"}, 32'(RGB), 32'(tbl[i].rgb));
        end

        // transparency at (0,0), then restore an opaque blue code
        wr_en = 1; wr_addr = 0; wr_data = 8'h00;
        set_pix(100, 50, 0, 100, 50);
        tick_clk();
        wr_en = 0;
        ticks(3);
        check("transp_vis", 32'(visible), 32'd0);
        check("transp_rgb", 32'(RGB), 32'h0);
        wr_en = 1; wr_data = 8'h03;
        tick_clk();
        wr_en = 0;
        ticks(3);
        check("blue_vis", 32'(visible), 32'd1);
        check("blue_rgb", 32'(RGB), 32'h0000FF);

        // write/read collision on the texel being rendered
        set_pix(100, 50, 0, 100, 52);
        ticks(3);
        check("coll_pre", 32'(RGB), 32'h00FFFF);
        wr_en = 1; wr_addr = 6'd8; wr_data = 8'h1C;
        tick_clk();
        wr_en = 0;
        check("coll_old", 32'(RGB), 32'h00FFFF);
        tick_clk();
        check("coll_new", 32'(RGB), 32'h00FF00);

        // animation stepping, wrap and hold behaviour
        set_pix(100, 50, 0, 0, 0);
        anim_en = 1;
        tick_clk();
        frame_ticks(14);
        check("anim_14", 32'(frame_idx), 32'd0);
        frame_ticks(1);
        check("anim_15", 32'(frame_idx), 32'd1);
        frame_ticks(45);
        check("anim_wrap60", 32'(frame_idx), 32'd0);
        frame_ticks(7);
        check("anim_7", 32'(frame_idx), 32'd0);
        anim_en = 0; frame_tick = 1;
        tick_clk();
        frame_tick = 0;
        tick_clk();
        check("anim_hold", 32'(frame_idx), 32'd0);
        anim_en = 1;
        tick_clk();
        frame_ticks(14);
        check("anim_fresh14", 32'(frame_idx), 32'd0);
        frame_ticks(1);
        check("anim_fresh15", 32'(frame_idx), 32'd1);

        // reset with writes pending; RAM must keep its contents
        anim_en = 0;
        set_pix(100, 50, 0, 100, 50);
        ticks(3);
        rst_n = 0; wr_en = 1; wr_addr = 0; wr_data = 8'hAA;
        ticks(3);
        check("reset_rgb", 32'(RGB), 32'h0);
        check("reset_vis", 32'(visible), 32'd0);
        check("reset_frame", 32'(frame_idx), 32'd0);
        rst_n = 1; wr_en = 0;
        ticks(3);
        check("ram_kept", 32'(RGB), 32'h0000FF);

        // random traffic against the model
        anim_en = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                x_pos = 10'($urandom_range(0, 1023));
                y_pos = 10'($urandom_range(0, 1023));
                scale = 2'($urandom_range(0, 3));
            end
            h_count = 10'(int'(x_pos) + int'($urandom_range(0, 72)) - 6);
            v_count = 10'(int'(y_pos) + int'($urandom_range(0, 72)) - 6);
            if ($urandom_range(0, 59) == 0) anim_en = ~anim_en;
            frame_tick = ($urandom_range(0, 2) == 0);
            wr_en = ($urandom_range(0, 5) == 0);
            wr_addr = 6'($urandom_range(0, 63));
            wr_data = 8'($urandom);
            tick_clk();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
